// File: rtl/shift_pkg.sv
// shift_pkg: shared op codes, data/amount widths and arbiter state encoding.
package shift_pkg;
    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;
    typedef enum logic [1:0] {OP_LSL = 2'b00, OP_LSR = 2'b01, OP_ASR = 2'b10, OP_ROR = 2'b11} op_t;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
endpackage

// File: rtl/shifter.sv
// shifter: combinational 32-bit barrel shifter supporting LSL, LSR, ASR and ROR.
module shifter
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMT_W-1:0]  i_amt,
    input  op_t               i_op,
    output logic [DATA_W-1:0] o_result
);
    logic [DATA_W-1:0] w_asr;
    logic [DATA_W-1:0] w_ror;
    // Kept in its own assign so the sign fill is not lost to unsigned context.
    assign w_asr = $signed(i_data) >>> i_amt;
    assign w_ror = DATA_W'({i_data, i_data} >> i_amt);
    assign o_result = (i_op == OP_LSL) ? i_data << i_amt :
                      (i_op == OP_LSR) ? i_data >> i_amt :
                      (i_op == OP_ASR) ? w_asr : w_ror;
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one shifter among NUM_REQ requesters, one-entry output register.
// Define SHIFT_ARB_STATS_EN to add the stat_ops handshake counter output.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*AMT_W-1:0]  req_amt,
    input  logic [NUM_REQ*2-1:0]      req_dir,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [ID_W-1:0]           rsp_id
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [31:0]               stat_ops
`endif
);
    state_t              r_state;
    state_t              w_next;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_result;
    logic [ID_W-1:0]     w_off;
    logic [ID_W-1:0]     w_grant;
    logic [ID_W:0]       w_sum;
    logic [NUM_REQ-1:0]  w_rot;
    logic                w_free;
    logic                w_accept;
    logic [DATA_W-1:0]   w_shift;
    logic [DATA_W-1:0]   w_data [NUM_REQ];
    logic [AMT_W-1:0]    w_amt  [NUM_REQ];
    op_t                 w_op   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_data[i] = req_data[i*DATA_W +: DATA_W];
        assign w_amt[i]  = req_amt[i*AMT_W +: AMT_W];
        assign w_op[i]   = op_t'(req_dir[i*2 +: 2]);
    end

    // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit is the winner's offset.
    assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);
    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (w_rot[k]) w_off = ID_W'(k);
    end
    assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_grant  = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ)) : ID_W'(w_sum);
    assign w_free   = (r_state == ST_EMPTY) || rsp_ready;
    assign w_accept = (|req_valid) && w_free && !rst;

    shifter u_shifter (
        .i_data   (w_data[w_grant]),
        .i_amt    (w_amt[w_grant]),
        .i_op     (w_op[w_grant]),
        .o_result (w_shift)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = w_accept ? ST_FULL : (rsp_ready ? ST_EMPTY : r_state);
    end

    always_comb begin
        rsp_valid = (r_state == ST_FULL);
        req_ready = w_accept ? NUM_REQ'(1) << w_grant : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_result <= w_shift;
            r_id     <= w_grant;
            r_rr_ptr <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
        end
    end

    assign rsp_result = r_result;
    assign rsp_id     = r_id;

`ifdef SHIFT_ARB_STATS_EN
    logic [31:0] r_stat_ops;
    always_ff @(posedge clk) begin
        if (rst)                          r_stat_ops <= '0;
        else if (rsp_valid && rsp_ready)  r_stat_ops <= r_stat_ops + 32'd1;
    end
    assign stat_ops = r_stat_ops;
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed and randomized checks of shift_arbiter against a cycle-level reference model.
module tb_shift_arbiter;
    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_data = '0;
    logic [N*5-1:0]  req_amt = '0;
    logic [N*2-1:0]  req_dir = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [31:0]     rsp_result;
    logic [0:0]      rsp_id;
`ifdef SHIFT_ARB_STATS_EN
    logic [31:0]     stat_ops;
`endif

    int vectors = 0;
    int miscompares = 0;

    bit          m_full = 0;
    logic [31:0] m_res = '0;
    int          m_id = 0;
    int          m_ptr = 0;
    logic [31:0] m_stats = '0;
    logic [N-1:0] exp_ready;
    logic [N-1:0] act_ready;

    shift_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_amt    (req_amt),
        .req_dir    (req_dir),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .stat_ops   (stat_ops)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(logic [31:0] d, int a, int op);
        case (op)
            0:       return d << a;
            1:       return d >> a;
            2:       return d[31] ? ~((~d) >> a) : d >> a;
            default: return (a == 0) ? d : ((d >> a) | (d << (32 - a)));
        endcase
    endfunction

    task automatic set_req(int i, bit v, logic [31:0] d, int a, int op);
        logic [4:0] a5;
        logic [1:0] o2;
        a5 = a[4:0];
        o2 = op[1:0];
        req_valid[i]        = v;
        req_data[i*32 +: 32] = d;
        req_amt[i*5 +: 5]   = a5;
        req_dir[i*2 +: 2]   = o2;
    endtask

    // One clock: predict grant from the current inputs, advance the model at the edge.
    task automatic cycle();
        int g;
        bit found;
        bit free;
        #1;
        free  = !m_full || rsp_ready;
        found = 0;
        g     = 0;
        for (int k = 0; k < N; k++)
            if (!found && req_valid[(m_ptr + k) % N]) begin
                found = 1;
                g = (m_ptr + k) % N;
            end
        exp_ready = (free && found && !rst) ? N'(1) << g : '0;
        act_ready = req_ready;
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_res = '0; m_id = 0; m_ptr = 0; m_stats = '0;
        end else begin
            if (m_full && rsp_ready) m_stats = m_stats + 1;
            if (exp_ready != '0) begin
                m_full = 1;
                m_res  = ref_shift(req_data[g*32 +: 32], int'(req_amt[g*5 +: 5]), int'(req_dir[g*2 +: 2]));
                m_id   = g;
                m_ptr  = (g + 1) % N;
            end else if (rsp_ready) begin
                m_full = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        rsp_ready = 1;
        set_req(0, 1, 32'h1, 1, 0);
        set_req(1, 1, 32'h2, 1, 0);
        cycle();
        cycle();
        vectors++; if (act_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b want 00", act_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_result !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
`ifdef SHIFT_ARB_STATS_EN
        vectors++; if (stat_ops !== 32'h0) begin miscompares++; $display("FAIL reset_stat_ops: got %0d want 0", stat_ops); end
`endif
        req_valid = '0;
        rst = 0;
        cycle();
    endtask

    typedef struct {
        int          id;
        logic [31:0] d;
        int          a;
        int          op;
        logic [31:0] e;
    } dvec_t;

    task automatic test_directed();
        dvec_t tbl [5];
        tbl[0] = '{0, 32'h00000001, 4, 0, 32'h00000010};
        tbl[1] = '{1, 32'h80000000, 4, 2, 32'hF8000000};
        tbl[2] = '{1, 32'h80000000, 4, 1, 32'h08000000};
        tbl[3] = '{0, 32'h0000000F, 4, 3, 32'hF0000000};
        tbl[4] = '{0, 32'h12345678, 0, 3, 32'h12345678};
        rsp_ready = 1;
        foreach (tbl[t]) begin
            req_valid = '0;
            set_req(tbl[t].id, 1, tbl[t].d, tbl[t].a, tbl[t].op);
            cycle();
            req_valid = '0;
            vectors++; if (act_ready !== N'(1) << tbl[t].id) begin miscompares++; $display("FAIL dir%0d_req_ready: got %b want %b", t, act_ready, N'(1) << tbl[t].id); end
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL dir%0d_rsp_valid: got %b want 1", t, rsp_valid); end
            vectors++; if (rsp_result !== tbl[t].e) begin miscompares++; $display("FAIL dir%0d_rsp_result: got %h want %h", t, rsp_result, tbl[t].e); end
            vectors++; if (rsp_id !== 1'(tbl[t].id)) begin miscompares++; $display("FAIL dir%0d_rsp_id: got %0d want %0d", t, rsp_id, tbl[t].id); end
            cycle();
        end
    endtask

    task automatic test_alternate();
        rst = 1;
        req_valid = '0;
        cycle();
        rst = 0;
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1, $urandom, $urandom_range(31), $urandom_range(3));
            set_req(1, 1, $urandom, $urandom_range(31), $urandom_range(3));
            cycle();
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL alt%0d_rsp_valid: got %b want 1", i, rsp_valid); end
            vectors++; if (rsp_id !== 1'(i % 2)) begin miscompares++; $display("FAIL alt%0d_rsp_id: got %0d want %0d", i, rsp_id, i % 2); end
            vectors++; if (rsp_result !== m_res) begin miscompares++; $display("FAIL alt%0d_rsp_result: got %h want %h", i, rsp_result, m_res); end
        end
        req_valid = '0;
        cycle();
    endtask

    task automatic test_back_pressure();
        logic [31:0] h_res;
        int h_id;
        rsp_ready = 1;
        set_req(0, 1, $urandom, $urandom_range(31), $urandom_range(3));
        set_req(1, 1, $urandom, $urandom_range(31), $urandom_range(3));
        cycle();
        h_res = m_res;
        h_id  = m_id;
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1, $urandom, $urandom_range(31), $urandom_range(3));
            set_req(1, 1, $urandom, $urandom_range(31), $urandom_range(3));
            cycle();
            vectors++; if (act_ready !== 2'b00) begin miscompares++; $display("FAIL bp%0d_req_ready: got %b want 00", i, act_ready); end
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp%0d_rsp_valid: got %b want 1", i, rsp_valid); end
            vectors++; if (rsp_result !== h_res) begin miscompares++; $display("FAIL bp%0d_rsp_result: got %h want %h", i, rsp_result, h_res); end
            vectors++; if (rsp_id !== 1'(h_id)) begin miscompares++; $display("FAIL bp%0d_rsp_id: got %0d want %0d", i, rsp_id, h_id); end
        end
        rsp_ready = 1;
        cycle();
        vectors++; if (act_ready !== N'(1) << (1 - h_id)) begin miscompares++; $display("FAIL bp_drain_req_ready: got %b want %b", act_ready, N'(1) << (1 - h_id)); end
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_drain_rsp_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_id !== 1'(1 - h_id)) begin miscompares++; $display("FAIL bp_drain_rsp_id: got %0d want %0d", rsp_id, 1 - h_id); end
        vectors++; if (rsp_result !== m_res) begin miscompares++; $display("FAIL bp_drain_rsp_result: got %h want %h", rsp_result, m_res); end
        req_valid = '0;
        cycle();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 0;
        req_valid = '0;
        set_req(0, 1, 32'hCAFEF00D, 3, 1);
        cycle();
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_fill_rsp_valid: got %b want 1", rsp_valid); end
        rst = 1;
        cycle();
        rst = 0;
        req_valid = '0;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_rsp_valid: got %b want 0", rsp_valid); end
`ifdef SHIFT_ARB_STATS_EN
        vectors++; if (stat_ops !== 32'h0) begin miscompares++; $display("FAIL rmid_stat_ops: got %0d want 0", stat_ops); end
`endif
        cycle();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_idle_rsp_valid: got %b want 0", rsp_valid); end
        rsp_ready = 1;
        set_req(0, 1, 32'h1, 1, 0);
        set_req(1, 1, 32'h1, 2, 0);
        cycle();
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL rmid_ptr_rsp_id: got %0d want 0", rsp_id); end
        vectors++; if (rsp_result !== 32'h2) begin miscompares++; $display("FAIL rmid_ptr_rsp_result: got %h want 2", rsp_result); end
        req_valid = '0;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(99) == 0);
            rsp_ready = ($urandom_range(9) < 7);
            for (int r = 0; r < N; r++)
                set_req(r, $urandom_range(1), $urandom, $urandom_range(31), $urandom_range(3));
            cycle();
            vectors++; if (act_ready !== exp_ready) begin miscompares++; $display("FAIL rnd%0d_req_ready: got %b want %b", i, act_ready, exp_ready); end
            vectors++; if (rsp_valid !== m_full) begin miscompares++; $display("FAIL rnd%0d_rsp_valid: got %b want %b", i, rsp_valid, m_full); end
            if (m_full) begin
                vectors++; if (rsp_result !== m_res) begin miscompares++; $display("FAIL rnd%0d_rsp_result: got %h want %h", i, rsp_result, m_res); end
                vectors++; if (rsp_id !== 1'(m_id)) begin miscompares++; $display("FAIL rnd%0d_rsp_id: got %0d want %0d", i, rsp_id, m_id); end
            end
`ifdef SHIFT_ARB_STATS_EN
            vectors++; if (stat_ops !== m_stats) begin miscompares++; $display("FAIL rnd%0d_stat_ops: got %0d want %0d", i, stat_ops, m_stats); end
`endif
        end
        rst = 0;
        req_valid = '0;
        cycle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_alternate();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one shifter (legal 2..4).
REQ-002 SHALL have derived localparam ID_W, value $clog2(NUM_REQ), requester-index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-007 SHALL have port req_data  input  NUM_REQ*32  operands, requester i in bits [32i+31:32i].
REQ-008 SHALL have port req_amt  input  NUM_REQ*5  shift amounts, requester i in bits [5i+4:5i].
REQ-009 SHALL have port req_dir  input  NUM_REQ*2  op codes: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 SHALL have port rsp_valid  output  1  registered result pending.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port rsp_result  output  32  shifted value.
REQ-013 SHALL have port rsp_id  output  ID_W  index of requester that owns rsp_result.

Function
REQ-014 SHALL implement a two-state FSM: EMPTY (no result held) and FULL (result held, rsp_valid=1).
REQ-015 SHALL accept a request only when a slot is free: slot free = EMPTY, or FULL with rsp_ready=1.
REQ-016 SHALL choose the grant combinationally by round-robin over asserted req_valid, starting at pointer rr_ptr; req_ready[g]=1 only for grant g and only when the slot is free.
REQ-017 SHALL, on accept (req_valid[g] & req_ready[g]), register shifter output into rsp_result, g into rsp_id, enter FULL, and set rr_ptr to (g+1) mod NUM_REQ.
REQ-018 SHALL give latency 1: accept in cycle N produces rsp_valid=1 in cycle N+1.
REQ-019 SHALL sustain one operation per cycle when rsp_ready=1 continuously (FULL->FULL with simultaneous drain and accept).
REQ-020 SHALL transition FULL->EMPTY when rsp_ready=1 and no accept occurs; FULL stays FULL with rsp_result/rsp_id stable while rsp_ready=0.
REQ-021 SHALL leave rr_ptr unchanged in cycles with no accept.
REQ-022 SHALL give ROR by 0 the unmodified operand and ASR the sign-filled right shift; all amounts 0..31 legal.
REQ-023 SHALL not require req_valid to be held; a withdrawn request is simply not granted.

Reset
REQ-024 SHALL, while rst=1, force EMPTY, rsp_valid=0, rsp_result=0, rsp_id=0, rr_ptr=0, req_ready=0.
REQ-025 SHALL discard any held result when rst asserts mid-operation; no response for it is ever issued.

Configuration
REQ-026 SHALL, when SHIFT_ARB_STATS_EN is defined, add output stat_ops (32 bits) counting rsp handshakes (rsp_valid & rsp_ready), wrapping at 2^32, reset to 0.
REQ-027 SHALL, when SHIFT_ARB_STATS_EN is undefined, omit stat_ops and its counter entirely.

Structure
REQ-028 SHALL place op-code constants (LSL/LSR/ASR/ROR) and data/amount widths in shared package shift_pkg.
REQ-029 SHALL instantiate exactly one existing shifter sub-module (named shifter) fed by a mux of the granted requester's data, amount and direction.

Verification
REQ-030 SHALL check: req0 LSL 0x00000001 by 4 -> next cycle rsp_valid=1, rsp_result=0x00000010, rsp_id=0.
REQ-031 SHALL check: req1 ASR 0x80000000 by 4 -> 0xF8000000; req1 LSR same operand -> 0x08000000.
REQ-032 SHALL check: req0 ROR 0x0000000F by 4 -> 0xF0000000; ROR 0x12345678 by 0 -> 0x12345678.
REQ-033 SHALL check: both requesters valid from first cycle after reset, rsp_ready=1 -> grants alternate 0,1,0,1, one result per cycle.
REQ-034 SHALL check: rsp_ready=0 for 3 cycles while FULL -> rsp_result/rsp_id stable, req_ready=0, then drain and accept in same cycle.
REQ-035 SHALL check: rst pulsed while FULL -> next cycle rsp_valid=0, rr_ptr=0, stat_ops=0 (if enabled).
